// File: rtl/regfile_dump_pkg.sv
// Shared widths and control constants for the register-file dump engine.
package regfile_dump_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_dump.sv
// Walks the register file through a shared read port, one granted read per
// register, and streams (address, data) pairs out on a valid/ready interface.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W    = REG_BUS_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              rf_grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_PTR = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_PTR  = '1;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;

  // NOTE: next_state gets its default before the case so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !abort) next_state = REQ;
      REQ: begin
        if (abort)         next_state = IDLE;
        else if (rf_grant) next_state = HOLD;
      end
      HOLD: begin
        if (abort)          next_state = IDLE;
        else if (out_ready) next_state = (ptr == LAST_PTR) ? DONE : REQ;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The read port is only driven while waiting for a grant.
  assign rf_re    = (state == REQ) ? READ_ENABLE : READ_DISABLE;
  assign rf_raddr = (state == REQ) ? ptr : '0;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every update sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IDLE;
      ptr       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      case (state)
        IDLE: if (next_state == REQ) ptr <= FIRST_PTR;
        REQ: begin
          if (next_state == HOLD) begin
            out_valid <= 1'b1;
            out_addr  <= ptr;
            out_data  <= rf_rdata;
          end
        end
        HOLD: begin
          // Abort and handshake both retire the word; abort simply skips the advance.
          if (next_state != HOLD) out_valid <= 1'b0;
          if (next_state == REQ)  ptr <= ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: transaction-level model compared every cycle, plus
// directed scenarios with hand-computed cycle counts and data values.
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic          start0;
  logic          abort;
  logic          rf_grant;
  logic          out_ready;

  logic          busy, done, rf_re, out_valid;
  logic [AW-1:0] rf_raddr, out_addr;
  logic [DW-1:0] rf_rdata, out_data;

  logic          busy0, done0, rf_re0, out_valid0;
  logic [AW-1:0] rf_raddr0, out_addr0;
  logic [DW-1:0] rf_rdata0, out_data0;

  logic [DW-1:0] mem [32];

  assign rf_rdata  = mem[rf_raddr];
  assign rf_rdata0 = mem[rf_raddr0];

  regfile_dump #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .rf_re(rf_re), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .rf_grant(rf_grant), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  regfile_dump #(.DATA_W(DW), .ADDR_W(AW), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .busy(busy0), .done(done0), .rf_re(rf_re0), .rf_raddr(rf_raddr0),
    .rf_rdata(rf_rdata0), .rf_grant(rf_grant), .out_valid(out_valid0),
    .out_ready(out_ready), .out_addr(out_addr0), .out_data(out_data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a dump is "active", either fetching (no word held), offering a
  // word, or finishing (done pulse). Updated on each rising edge.
  bit            m_busy, m_valid, m_done, m_re;
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            cmp_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_ptr = 0; m_addr = '0; m_data = '0;
    end else if (!m_busy) begin
      if (start && !abort) begin m_busy = 1; m_ptr = 1; end
    end else if (abort) begin
      m_busy = 0; m_valid = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_valid) begin
      if (rf_grant) begin m_valid = 1; m_addr = AW'(m_ptr); m_data = mem[m_ptr]; end
    end else if (out_ready) begin
      m_valid = 0;
      if (m_ptr == 31) m_done = 1;
      else m_ptr++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      m_re = m_busy && !m_valid && !m_done;
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("rf_re", rf_re, m_re);
      check("rf_raddr", rf_raddr, m_re ? m_ptr : 0);
      check("out_valid", out_valid, m_valid);
      check("out_addr", out_addr, m_addr);
      check("out_data", out_data, m_data);
    end
  end

  // Handshake and done-pulse counters for the directed checks.
  int hs [32];
  int hs_total, hs0_total, done_cnt;

  always @(posedge clk) begin
    if (!rst && !abort && out_valid === 1'b1 && out_ready) begin
      hs[out_addr]++;
      hs_total++;
    end
    if (!rst && !abort && out_valid0 === 1'b1 && out_ready) hs0_total++;
    if (!rst && done === 1'b1) done_cnt++;
  end

  task automatic clear_counts();
    foreach (hs[i]) hs[i] = 0;
    hs_total = 0; hs0_total = 0; done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 200 && busy; n++) @(negedge clk);
    check({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic wait_word(input string name, input int addr);
    int n;
    for (n = 0; n < 200 && !(out_valid && out_addr == AW'(addr)); n++) @(negedge clk);
    check({name, "_word_timeout"}, out_valid && out_addr == AW'(addr), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int first_v, done_c, fall_c, n, last_a;
    logic [DW-1:0] last_d;

    rst = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    rf_grant = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    clear_counts();

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rf_re", rf_re, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy0", busy0, 1'b0);
    rst = 1'b0;
    cmp_en = 1;

    // Full dump: start driven in cycle 0, beat i valid in cycle 2i.
    @(negedge clk);
    clear_counts();
    first_v = -1; done_c = -1; fall_c = -1; last_d = '0;
    start = 1'b1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        check("full_beat_cycle", c, 2 * out_addr);
        last_d = out_data;
      end
      if (done) done_c = c;
      if (!busy) begin fall_c = c; break; end
    end
    check("full_first_valid", first_v, 2);
    check("full_done_cycle", done_c, 63);
    check("full_busy_fall", fall_c, 64);
    check("full_beats", hs_total, 31);
    check("full_no_r0", hs[0], 0);
    check("full_last_data", last_d, 32'h1000_001F);
    check("full_done_count", done_cnt, 1);

    // Back-pressure on r7: six HOLD cycles, ready low for the first five.
    clear_counts();
    pulse_start();
    for (n = 0; n < 100 && !(rf_re && rf_raddr == 5'd7); n++) @(negedge clk);
    check("bp_req_timeout", rf_re && rf_raddr == 5'd7, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_addr", out_addr, 7);
      check("bp_data", out_data, 32'h1000_0007);
      check("bp_rf_re", rf_re, 1'b0);
      if (i == 5) out_ready = 1'b1;
    end
    wait_idle("bp");
    check("bp_r7_once", hs[7], 1);
    check("bp_beats", hs_total, 31);
    check("bp_done_count", done_cnt, 1);

    // Grant denied for 4 cycles on r3; a write lands mid-wait.
    clear_counts();
    pulse_start();
    wait_word("gd", 2);
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("gd_rf_re", rf_re, 1'b1);
      check("gd_raddr", rf_raddr, 3);
      check("gd_valid", out_valid, 1'b0);
      if (i == 1) mem[3] = 32'hDEAD_0003;
    end
    rf_grant = 1'b1;
    @(negedge clk);
    check("gd_cap_valid", out_valid, 1'b1);
    check("gd_cap_addr", out_addr, 3);
    check("gd_cap_data", out_data, 32'hDEAD_0003);
    mem[3] = 32'h1000_0003;
    check("gd_held_data", out_data, 32'hDEAD_0003);
    wait_idle("gd");
    check("gd_beats", hs_total, 31);

    // Abort in HOLD on r10 with ready high; restart from r1.
    clear_counts();
    pulse_start();
    wait_word("ab", 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_valid", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("ab_no_r10", hs[10], 0);
    check("ab_beats", hs_total, 9);
    check("ab_no_done", done_cnt, 0);
    pulse_start();
    check("ab_restart_re", rf_re, 1'b1);
    check("ab_restart_addr", rf_raddr, 1);
    wait_idle("ab");
    check("ab_r10_after", hs[10], 1);
    check("ab_done_after", done_cnt, 1);

    // Reset mid-dump on r20, then start together with abort in IDLE.
    clear_counts();
    pulse_start();
    wait_word("rs", 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_busy", busy, 1'b0);
    check("rs_done", done, 1'b0);
    check("rs_rf_re", rf_re, 1'b0);
    check("rs_raddr", rf_raddr, 0);
    check("rs_valid", out_valid, 1'b0);
    check("rs_addr", out_addr, 0);
    check("rs_data", out_data, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("sa_busy_later", busy, 1'b0);
    check("sa_rf_re", rf_re, 1'b0);
    check("rs_no_done", done_cnt, 0);

    // Dump starting at r0: 32 beats, done in cycle 65.
    clear_counts();
    first_v = -1; done_c = -1; fall_c = -1; last_a = -1;
    start0 = 1'b1;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
      if (out_valid0) begin
        if (first_v < 0) begin
          first_v = c;
          check("z0_first_addr", out_addr0, 0);
          check("z0_first_data", out_data0, 0);
        end
        check("z0_beat_cycle", c, 2 * out_addr0 + 2);
        last_a = out_addr0;
      end
      if (done0) done_c = c;
      if (!busy0) begin fall_c = c; break; end
    end
    check("z0_first_valid", first_v, 2);
    check("z0_done_cycle", done_c, 65);
    check("z0_busy_fall", fall_c, 66);
    check("z0_beats", hs0_total, 32);
    check("z0_last_addr", last_a, 31);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug/scan engine that reads the general-purpose register file sequentially through one of its read ports.
- Streams each (address, data) pair out on a valid/ready interface toward the debug/trace path.
- Sits beside the decode stage's read port. It uses that port only in cycles when the port arbiter grants it, so normal pipeline reads are never disturbed.
- Read side of the register file seen from the outside: it drives re/raddr and consumes the combinational rdata.

Parameters:
- DATA_W, 32, register width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus); register count = 2**ADDR_W.
- SKIP_ZERO, 1, 1 = dump starts at r1 (31 beats); 0 = dump starts at r0 (32 beats).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  cancel the dump in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- rf_re  out  1  read enable to the register file read port.
- rf_raddr  out  ADDR_W  read address to the register file.
- rf_rdata  in  DATA_W  combinational read data returned in the same cycle.
- rf_grant  in  1  read port is free for this block in the current cycle.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream sink ready.
- out_addr  out  ADDR_W  register index of the current word.
- out_data  out  DATA_W  register contents of the current word.

Behaviour:
- Reset: clk is the clock; rst is a synchronous, active-high reset. On rst:
  - state = IDLE.
  - busy, done, rf_re, rf_raddr, out_valid, out_addr, out_data all 0; ptr = 0.
  - rst mid-dump aborts immediately with no done pulse.
- State machine: IDLE, REQ, HOLD, DONE. All outputs are registered except rf_re and rf_raddr, which decode from state and ptr.
- IDLE:
  - start=1 and abort=0 -> REQ, with ptr = SKIP_ZERO ? 1 : 0.
  - start together with abort -> stay in IDLE.
- REQ:
  - rf_re=1 and rf_raddr=ptr.
  - If rf_grant=1: capture out_data <= rf_rdata and out_addr <= ptr, set out_valid <= 1, go to HOLD.
  - If rf_grant=0: stay in REQ and keep presenting the same address; no limit on wait cycles.
- HOLD:
  - rf_re=0 and rf_raddr=0.
  - out_valid, out_addr and out_data stay stable until out_ready=1.
  - On handshake, out_valid <= 0. Then:
    - ptr = all-ones (last register) -> DONE.
    - otherwise ptr <= ptr+1 -> REQ.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
- Abort: abort=1 in REQ, HOLD or DONE -> IDLE next edge.
  - out_valid cleared; no done pulse.
  - A HOLD word is dropped even if out_ready=1 in the same cycle (abort has priority).
- start is ignored while busy=1.
- Pointer: ptr never wraps. Termination is detected at all-ones before increment.
- Register zero: data is whatever rf_rdata returns; the register file returns 0. No special-casing here.
- Throughput: one word per 2 cycles minimum (REQ + HOLD). Read-port occupancy is exactly one granted cycle per word.
- Data is captured only on a granted cycle. If rf_rdata changes after capture (a later pipeline write), the streamed value does not change.

Decomposition:
- Shared package/defines supply:
  - RegBus and RegAddrBus widths.
  - RstEnable.
  - ReadEnable/ReadDisable.
  - ZeroWord.
  - State encoding localparams (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DONE=2'd3), kept local to this module.
- No sub-module; single FSM plus a pointer counter and an output register.

Test Plan:
- Full dump, SKIP_ZERO=1, rf_grant=1, out_ready=1, register file preloaded with rN = 0x1000_0000+N, start pulsed at edge 0 -> 31 beats with out_addr 1..31 and out_data 0x1000_0001..0x1000_001F. Beat i has valid in cycle 2i; done pulses in cycle 63; busy falls in cycle 64.
- Back-pressure: out_ready held 0 for 5 cycles on beat r7 -> out_valid, out_addr=7 and out_data stable for all 6 cycles; rf_re=0 throughout; exactly one r7 beat.
- Grant denial: rf_grant=0 for 4 cycles while in REQ for r3 -> rf_re=1 and rf_raddr=3 held for 4 cycles. Capture on the first granted cycle; a register write landing during the wait is reflected in the captured data.
- Abort in HOLD with out_ready=1 on beat r10 -> no r10 handshake; IDLE next cycle; out_valid=0; done never pulses. A following start restarts from r1.
- rst asserted for 1 cycle mid-dump at r20 -> all outputs 0 next cycle, no done. start with abort in IDLE -> busy stays 0.
- SKIP_ZERO=0 -> 32 beats; first beat out_addr=0, out_data=0; last beat out_addr=31; done pulses in cycle 65.
